// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use and mul/div hazard detection driving PC/IF-ID write enables, flush and bubble mux.
module hazard_stall_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_STALL = 1,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_reg_rt,
  input  logic [REG_ADDR_W-1:0] if_id_reg_rs,
  input  logic [REG_ADDR_W-1:0] if_id_reg_rt,
  input  logic                  if_id_uses_rt,
  input  logic                  if_id_md_use,
  input  logic                  ex_md_start,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  mux_select_stall,
  output logic                  if_id_flush,
  output logic                  md_busy,
  output logic [CNT_W-1:0]      stall_cnt
);
  typedef enum logic {IDLE, LD_STALL} state_t;
  state_t     state;
  logic [2:0] ld_cnt;
  logic [3:0] md_cnt;
  logic       ld_hit, md_stall, stall;
  assign ld_hit = id_ex_mem_read && id_ex_reg_rt != '0 &&
                  (id_ex_reg_rt == if_id_reg_rs || (if_id_uses_rt && id_ex_reg_rt == if_id_reg_rt));
  assign md_busy  = md_cnt != 4'd0;
  assign md_stall = md_busy && if_id_md_use;
  assign stall    = (state == IDLE && ld_hit) || state == LD_STALL || md_stall;
  // Outputs are gated by rst_n so an asserted reset releases the pipeline at once.
  always_comb begin
    pc_write         = !rst_n || branch_taken || !stall;
    if_id_write      = !rst_n || branch_taken || !stall;
    mux_select_stall = rst_n && (branch_taken || stall);
    if_id_flush      = rst_n && branch_taken;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ld_cnt    <= 3'd0;
      md_cnt    <= 4'd0;
      stall_cnt <= '0;
    end else begin
      if (branch_taken) begin
        state  <= IDLE;
        ld_cnt <= 3'd0;
      end else if (state == IDLE) begin
        if (ld_hit) begin
          ld_cnt <= 3'(LOAD_STALL - 1);
          state  <= (LOAD_STALL > 1) ? LD_STALL : IDLE;
        end
      end else begin
        ld_cnt <= ld_cnt - 3'd1;
        state  <= (ld_cnt == 3'd1) ? IDLE : LD_STALL;
      end
      md_cnt    <= ex_md_start ? 4'(MD_LAT) : (md_busy ? md_cnt - 4'd1 : 4'd0);
      stall_cnt <= pc_write ? '0 : (&stall_cnt ? stall_cnt : stall_cnt + 1'b1);
    end
  end
endmodule
